// File: rtl/avr_fetch_unit.sv
// AVR instruction fetch: PC, ROM read issue, prefetch queue and two-word assembly.
// Define FETCH_STATS_EN to add the stat_issued / stat_stall / stat_flush counters.
module avr_fetch_unit #(
  parameter int                ADDR_W   = 14,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr_word,
  output logic [15:0]       instr_ext,
  output logic              instr_is32,
  output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stall,
  output logic [15:0]       stat_flush
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic is_two_word(input logic [15:0] w);
    return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
  endfunction

  logic [15:0]       word_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, head_nxt;
  logic [CNT_W-1:0]  count_q, count_d, pop_n;
  logic [CNT_W:0]    occupancy;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q;
  logic              inflight_q;
  logic              head_is32, have_any, push, xfer;

  assign head_nxt  = head_q + PTR_W'(1);
  assign head_is32 = is_two_word(word_q[head_q]);
  assign have_any  = (count_q != '0);
  // In-flight reads are reserved at issue so a returning word always has a slot.
  assign occupancy = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q);

  assign rom_rd_en = !reset && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
  assign rom_addr  = fetch_pc_q;

  assign instr_valid = !reset && !redirect_valid && have_any &&
                       (!head_is32 || (count_q >= CNT_W'(2)));
  assign instr_word  = have_any ? word_q[head_q] : 16'h0000;
  assign instr_pc    = have_any ? pc_q[head_q] : '0;
  assign instr_is32  = have_any && head_is32;
  assign instr_ext   = instr_is32 ? word_q[head_nxt] : 16'h0000;

  assign xfer = instr_valid && instr_ready;
  // A redirect discards whatever returns in the same cycle.
  assign push = inflight_q && !redirect_valid;

  always_comb begin
    pop_n      = '0;
    if (xfer) pop_n = instr_is32 ? CNT_W'(2) : CNT_W'(1);
    head_d     = head_q + PTR_W'(pop_n);
    tail_d     = tail_q + PTR_W'(push);
    count_d    = count_q + CNT_W'(push) - pop_n;
    fetch_pc_d = fetch_pc_q + ADDR_W'(rom_rd_en);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_pc_q    <= redirect_pc;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= rom_rd_en;
      inflight_pc_q <= fetch_pc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      word_q[tail_q] <= rom_data;
      pc_q[tail_q]   <= inflight_pc_q;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] issued_q, stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      issued_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      issued_q <= issued_q + 32'(xfer);
      stall_q  <= stall_q + 32'(instr_valid && !instr_ready);
      flush_q  <= flush_q + 16'(redirect_valid);
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
  assign stat_flush  = flush_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/avr_fetch_unit.md
Name: avr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder in the ATmega32A core.
- Owns the program counter and issues word reads to the synchronous program ROM.
- Buffers returned words in a small prefetch queue and assembles AVR two-word instructions (LDS/STS/JMP/CALL) into one 32-bit item.
- Hands instructions to the decoder over a valid/ready handshake and flushes on branch redirect.

Parameters:
ADDR_W, 14, program word-address width (16K words = 32 KB flash)
DEPTH, 4, prefetch queue depth in 16-bit words; power of two, >= 2
RESET_PC, 0, word address fetched first after reset

Ports:
clock  input  1  core clock
reset  input  1  reset, synchronous, active-high
rom_rd_en  output  1  ROM read strobe
rom_addr  output  ADDR_W  ROM word address
rom_data  input  16  ROM word; valid the cycle after rom_rd_en
redirect_valid  input  1  branch/jump taken; flush and restart
redirect_pc  input  ADDR_W  new fetch word address
instr_valid  output  1  instruction available to decoder
instr_ready  input  1  decoder accepts instruction
instr_word  output  16  first (opcode) word
instr_ext  output  16  second word when instr_is32, else 0
instr_is32  output  1  two-word instruction
instr_pc  output  ADDR_W  word address of instr_word

Behaviour:
- Reset, synchronous: fetch_pc = RESET_PC; queue empty; in-flight cleared; rom_rd_en = 0; instr_valid = 0; instr_word, instr_ext, instr_is32 and instr_pc = 0.
- Read issue: rom_rd_en = 1 when not reset, not redirect_valid, and (count + inflight) < DEPTH.
  - rom_addr = fetch_pc.
  - fetch_pc increments by 1 per issued read and wraps 2^ADDR_W-1 -> 0.
  - At most one read outstanding per cycle.
- Read return: the word returned in cycle N+1 for a read issued in cycle N is written to the queue tail at the end of N+1, with its pc, unless killed.
- Two-word detect, applied to the head word:
  - (w & 16'hFC0F) == 16'h9000 covers LDS/STS.
  - (w & 16'hFE0C) == 16'h940C covers JMP/CALL.
- Output:
  - instr_valid = count >= 1 and (not is32(head) or count >= 2).
  - Outputs are driven combinationally from the queue head.
  - instr_ext = head+1 word when is32, else 0.
- Transfer on instr_valid & instr_ready pops 1 word (16-bit) or 2 words (32-bit).
- Push and pop in the same cycle are allowed; count updates by the net amount.
- Redirect in cycle N:
  - Queue is flushed at the end of N.
  - The in-flight read is killed and its return is discarded.
  - instr_valid is forced 0 during N, so no transfer occurs in N.
  - fetch_pc = redirect_pc at the end of N.
  - First read is issued in N+1; a 16-bit instruction becomes instr_valid in N+3.
- Redirect has priority over any push or pop in the same cycle.
- Reset deasserted after cycle R: first read in R+1; instr_valid earliest in R+3.
- Full queue: no reads issue and the returned word is always accepted, because inflight is counted at issue.
- Wrap-around: a 32-bit instruction at address 2^ADDR_W-1 takes its ext word from address 0.
- Stall: while instr_ready = 0, the outputs hold stable and the queue fills, then reads stop.
- A 32-bit head with only one word queued holds instr_valid = 0 until its second word arrives.

Optional Feature:
- Macro FETCH_STATS_EN enables three free-running counters, each cleared by reset and wrapping on overflow:
  - stat_issued (output, 32): instructions transferred.
  - stat_stall (output, 32): cycles with instr_valid=1 & instr_ready=0.
  - stat_flush (output, 16): redirect_valid cycles.
- Without FETCH_STATS_EN, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release with ROM[0..3] = 0xE00F, 0x2411, 0x0000, 0x0000 and ready=1 -> instr_valid in R+3 with word 0xE00F, pc 0, is32 0; next cycle word 0x2411, pc 1.
- ROM[0..1] = 0x940C, 0x0123 (JMP) -> a single transfer: instr_word 0x940C, instr_ext 0x0123, is32 1, pc 0; next instr_pc = 2.
- ready=0 for 10 cycles -> at most DEPTH reads outstanding or queued, rom_rd_en low once full, outputs stable; on ready=1, sequential pcs with none lost or duplicated.
- redirect_valid with redirect_pc=0x0100 while the queue is full and a read is in flight -> no stale word is delivered; the first delivered instr_pc is 0x100 at cycle N+3.
- redirect_pc=0x3FFF with ROM[0x3FFF]=0x9100 (LDS) and ROM[0]=0x0060 -> instr_ext 0x0060, is32 1; following pc is 1.
- FETCH_STATS_EN: 5 transfers, 3 stall cycles and 1 redirect -> stat_issued=5, stat_stall=3, stat_flush=1; reset clears all to 0.
